// File: rtl/ts_fifo_bank_arb.sv
// ----------------------------------------------------------------------------
// ts_fifo_bank_arb
//
// N-channel transport-stream input buffer bank. Each channel writes bytes into
// its own FIFO (no backpressure towards the sources). A packet-granular
// round-robin arbiter picks a channel that holds at least one whole packet and
// streams exactly PKT_LEN words from it over a ready/valid output.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    packed channel data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   per-channel write strobe
//   out_data   merged stream data (0 while out_valid is low)
//   out_valid  out_data holds a word
//   out_ready  downstream accepts the word when out_valid && out_ready
//   out_last   marks the PKT_LEN-th word of a packet
//   out_ch     channel that owns the current packet
//   ch_full    per-channel FIFO holds DEPTH words (registered)
//   ovf        sticky per-channel "write dropped because full"
//   ovf_clr    per-channel clear pulse for ovf (a same-cycle drop wins)
// ----------------------------------------------------------------------------
module ts_fifo_bank_arb #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int PKT_LEN    = 188,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int CNT_W     = ADDR_WIDTH + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH*DATA_WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]            in_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [CH_W-1:0]            out_ch,
  output logic [N_CH-1:0]            ch_full,
  output logic [N_CH-1:0]            ovf,
  input  logic [N_CH-1:0]            ovf_clr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Per-channel FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem    [N_CH][DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr [N_CH];
  logic [ADDR_WIDTH-1:0] rd_ptr [N_CH];
  logic [CNT_W-1:0]      count      [N_CH];
  logic [CNT_W-1:0]      count_next [N_CH];

  logic [N_CH-1:0] wr_en;
  logic [N_CH-1:0] drop;
  logic [N_CH-1:0] pop;
  logic [N_CH-1:0] eligible;

  // Arbiter / output state
  state_t                state;
  logic [CH_W-1:0]       last_grant;
  logic [CH_W-1:0]       next_grant;
  logic                  any_elig;
  logic [CNT_W-1:0]      word_cnt;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] rd_next;

  // --------------------------------------------------------------------------
  // Per-channel write/pop decode
  // --------------------------------------------------------------------------
  always_comb begin
    xfer = (state == SEND) && out_valid && out_ready;
    for (int i = 0; i < N_CH; i++) begin
      // A full FIFO drops the write even if a pop happens in the same cycle.
      wr_en[i]    = in_valid[i] && (count[i] != CNT_W'(DEPTH));
      drop[i]     = in_valid[i] && (count[i] == CNT_W'(DEPTH));
      pop[i]      = xfer && (out_ch == CH_W'(i));
      eligible[i] = (count[i] >= CNT_W'(PKT_LEN));
      case ({wr_en[i], pop[i]})
        2'b10:   count_next[i] = count[i] + 1'b1;
        2'b01:   count_next[i] = count[i] - 1'b1;
        default: count_next[i] = count[i];
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin search starting just after the last granted channel
  // --------------------------------------------------------------------------
  always_comb begin
    any_elig   = 1'b0;
    next_grant = last_grant;
    for (int k = 1; k <= N_CH; k++) begin
      if (!any_elig && eligible[(int'(last_grant) + k) % N_CH]) begin
        any_elig   = 1'b1;
        next_grant = CH_W'((int'(last_grant) + k) % N_CH);
      end
    end
  end

  // Address of the word that follows the current head of the granted FIFO
  assign rd_next = rd_ptr[out_ch] + 1'b1;

  // --------------------------------------------------------------------------
  // FIFO storage
  // --------------------------------------------------------------------------
  // NOTE: the storage array is deliberately not reset; validity of each slot
  // is defined by the pointers and counts, which are reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (wr_en[i]) begin
        mem[i][wr_ptr[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers, counts, full and overflow flags
  // --------------------------------------------------------------------------
  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      ch_full <= '0;
      ovf     <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])   rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i]   <= count_next[i];
        ch_full[i] <= (count_next[i] == CNT_W'(DEPTH));
        // Drop has priority over a coincident clear.
        if (drop[i]) begin
          ovf[i] <= 1'b1;
        end else if (ovf_clr[i]) begin
          ovf[i] <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Packet arbiter FSM with registered outputs.
  // out_data is preloaded with the head word at grant and with the following
  // word on each non-final transfer; the whole packet is already stored at
  // grant, so that following word is always present.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= CH_W'(N_CH - 1);  // channel 0 searched first
      word_cnt   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_ch     <= '0;
      out_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_elig) begin
            state      <= SEND;
            out_ch     <= next_grant;
            last_grant <= next_grant;
            word_cnt   <= '0;
            out_valid  <= 1'b1;
            out_last   <= 1'b0;
            out_data   <= mem[next_grant][rd_ptr[next_grant]];
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              word_cnt  <= '0;
            end else begin
              word_cnt <= word_cnt + 1'b1;
              out_last <= (word_cnt + 1'b1 == CNT_W'(PKT_LEN - 1));
              out_data <= mem[out_ch][rd_next];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ts_fifo_bank_arb.sv
// ----------------------------------------------------------------------------
// tb_ts_fifo_bank_arb
//
// Self-checking bench for ts_fifo_bank_arb with N_CH=4, DATA_WIDTH=8,
// ADDR_WIDTH=4 (DEPTH=16), PKT_LEN=4. Accepted writes go into per-channel
// model queues; the expected grant order is queued by each scenario. A
// negedge monitor compares every output word, flag and idle value.
// ----------------------------------------------------------------------------
module tb_ts_fifo_bank_arb;

  localparam int N_CH  = 4;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int PKT   = 4;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_CH*DW-1:0] in_data  = '0;
  logic [N_CH-1:0]   in_valid = '0;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic [1:0]        out_ch;
  logic [N_CH-1:0]   ch_full;
  logic [N_CH-1:0]   ovf;
  logic [N_CH-1:0]   ovf_clr = '0;

  ts_fifo_bank_arb #(
    .N_CH      (N_CH),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .PKT_LEN   (PKT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .out_ch   (out_ch),
    .ch_full  (ch_full),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  logic [DW-1:0]   mq [N_CH][$];   // model FIFO contents
  int              exp_ch_q [$];   // expected packet grant order
  int              gap_q [$];      // idle cycles before each non-first packet
  logic [N_CH-1:0] m_full = '0;
  logic [N_CH-1:0] m_ovf  = '0;
  bit              in_pkt  = 1'b0;
  bit              had_pkt = 1'b0;
  int              wc      = 0;
  int              cur_ch  = 0;
  int              idle_cnt = 0;

  // Monitor / model, sampled on the falling edge
  initial begin
    logic [N_CH-1:0] acc;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int c = 0; c < N_CH; c++) mq[c].delete();
        exp_ch_q.delete();
        gap_q.delete();
        m_full   = '0;
        m_ovf    = '0;
        in_pkt   = 1'b0;
        had_pkt  = 1'b0;
        wc       = 0;
        idle_cnt = 0;
      end else begin
        check("ch_full", 32'(ch_full), 32'(m_full));
        check("ovf", 32'(ovf), 32'(m_ovf));
        for (int c = 0; c < N_CH; c++) acc[c] = in_valid[c] && (mq[c].size() < DEPTH);

        if (out_valid) begin
          if (!in_pkt) begin
            if (had_pkt) gap_q.push_back(idle_cnt);
            check("pkt_expected", 32'(exp_ch_q.size() != 0), 32'd1);
            if (exp_ch_q.size() != 0) cur_ch = exp_ch_q.pop_front();
            else                      cur_ch = int'(out_ch);
            in_pkt = 1'b1;
            wc     = 0;
          end
          check("out_ch", 32'(out_ch), 32'(cur_ch));
          if (mq[cur_ch].size() == 0) begin
            check("model_has_word", 32'd0, 32'd1);
          end else begin
            check("out_data", 32'(out_data), 32'(mq[cur_ch][0]));
          end
          check("out_last", 32'(out_last), 32'(wc == PKT - 1));
          if (out_ready) begin
            if (mq[cur_ch].size() != 0) void'(mq[cur_ch].pop_front());
            if (wc == PKT - 1) begin
              in_pkt   = 1'b0;
              had_pkt  = 1'b1;
              idle_cnt = 0;
            end else begin
              wc++;
            end
          end
        end else begin
          if (in_pkt) begin
            check("valid_held_mid_pkt", 32'(out_valid), 32'd1);
            in_pkt = 1'b0;
          end
          check("idle_data", 32'(out_data), 32'd0);
          check("idle_last", 32'(out_last), 32'd0);
          idle_cnt++;
        end

        for (int c = 0; c < N_CH; c++) begin
          if (acc[c]) mq[c].push_back(in_data[c*DW +: DW]);
          m_full[c] = (mq[c].size() == DEPTH);
          if (in_valid[c] && !acc[c]) m_ovf[c] = 1'b1;
          else if (ovf_clr[c])        m_ovf[c] = 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (all called at posedge + 1)
  // --------------------------------------------------------------------------
  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = '0;
    ovf_clr   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic write_cycle(input logic [N_CH-1:0] mask, input logic [N_CH*DW-1:0] data);
    in_valid = mask;
    in_data  = data;
    @(posedge clk);
    #1 in_valid = '0;
  endtask

  task automatic write_word(input int ch, input logic [DW-1:0] d);
    logic [N_CH-1:0]    m;
    logic [N_CH*DW-1:0] v;
    m = '0;
    v = '0;
    m[ch] = 1'b1;
    v[ch*DW +: DW] = d;
    write_cycle(m, v);
  endtask

  task automatic wait_valid(input int max_cycles);
    int i = 0;
    while (!out_valid && i < max_cycles) begin
      @(posedge clk);
      #1 i++;
    end
    check("wait_valid_timeout", 32'(i < max_cycles), 32'd1);
  endtask

  task automatic wait_done(input int max_cycles);
    int i = 0;
    while ((exp_ch_q.size() != 0 || in_pkt || out_valid) && i < max_cycles) begin
      @(posedge clk);
      #1 i++;
    end
    check("drain_timeout", 32'(i < max_cycles), 32'd1);
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  initial begin
    // 1. Asynchronous reset mid-run, then a partial packet is not sent
    do_reset();
    exp_ch_q.push_back(0);
    for (int k = 0; k < DEPTH + 1; k++) write_word(0, 8'(k));
    check("t1_pre_valid", 32'(out_valid), 32'd1);
    check("t1_pre_ovf", 32'(ovf[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t1_rst_valid", 32'(out_valid), 32'd0);
    check("t1_rst_last", 32'(out_last), 32'd0);
    check("t1_rst_full", 32'(ch_full), 32'd0);
    check("t1_rst_ovf", 32'(ovf), 32'd0);
    check("t1_rst_data", 32'(out_data), 32'd0);
    check("t1_rst_ch", 32'(out_ch), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < PKT - 1; k++) write_word(0, 8'(8'hA0 + k));
    for (int k = 0; k < 6; k++) begin
      check("t1_no_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end

    // 2. Single packet on ch2, latency and ordering
    do_reset();
    out_ready = 1'b1;
    exp_ch_q.push_back(2);
    write_word(2, 8'h47);
    write_word(2, 8'h01);
    write_word(2, 8'h02);
    write_word(2, 8'h03);
    check("t2_valid_at_k", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("t2_valid_at_k1", 32'(out_valid), 32'd1);
    check("t2_ch", 32'(out_ch), 32'd2);
    check("t2_first", 32'(out_data), 32'h47);
    wait_done(40);
    check("t2_idle_after", 32'(out_valid), 32'd0);

    // 3. Round robin ch0, ch1, ch3, then refilled ch0
    do_reset();
    out_ready = 1'b1;
    exp_ch_q.push_back(0);
    exp_ch_q.push_back(1);
    exp_ch_q.push_back(3);
    exp_ch_q.push_back(0);
    for (int k = 0; k < PKT; k++) begin
      write_cycle(4'b1011, {8'(8'h30 + k), 8'h00, 8'(8'h10 + k), 8'(k)});
    end
    begin
      int i = 0;
      while (!(out_valid && out_ch == 2'd3) && i < 60) begin
        @(posedge clk);
        #1 i++;
      end
      check("t3_ch3_seen", 32'(i < 60), 32'd1);
    end
    for (int k = 0; k < PKT; k++) write_word(0, 8'(8'h04 + k));
    wait_done(80);
    check("t3_gap_count", 32'(gap_q.size()), 32'd3);
    while (gap_q.size() != 0) check("t3_gap", 32'(gap_q.pop_front()), 32'd1);

    // 4. Backpressure at word 2 of a ch1 packet
    do_reset();
    out_ready = 1'b1;
    exp_ch_q.push_back(1);
    for (int k = 0; k < PKT; k++) write_word(1, 8'(8'h10 + k));
    wait_valid(20);
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    check("t4_word2", 32'(out_data), 32'h12);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("t4_hold_data", 32'(out_data), 32'h12);
      check("t4_hold_last", 32'(out_last), 32'd0);
      check("t4_hold_ch", 32'(out_ch), 32'd1);
    end
    out_ready = 1'b1;
    wait_done(40);

    // 5. Overflow on ch1 and ovf_clr priority
    do_reset();
    out_ready = 1'b0;
    for (int p = 0; p < DEPTH / PKT; p++) exp_ch_q.push_back(1);
    for (int k = 0; k <= DEPTH; k++) write_word(1, 8'(k));
    check("t5_full", 32'(ch_full[1]), 32'd1);
    check("t5_ovf", 32'(ovf[1]), 32'd1);
    ovf_clr[1] = 1'b1;
    @(posedge clk);
    #1 ovf_clr = '0;
    check("t5_ovf_cleared", 32'(ovf[1]), 32'd0);
    ovf_clr[1] = 1'b1;
    write_word(1, 8'h11);
    ovf_clr = '0;
    check("t5_ovf_set_wins", 32'(ovf[1]), 32'd1);
    out_ready = 1'b1;
    wait_done(120);
    check("t5_not_full", 32'(ch_full[1]), 32'd0);

    // 6. Simultaneous write and read on ch3 with count at 5
    do_reset();
    out_ready = 1'b0;
    for (int p = 0; p < 3; p++) exp_ch_q.push_back(3);
    for (int k = 0; k < 5; k++) write_word(3, 8'(8'h30 + k));
    out_ready = 1'b1;
    for (int k = 5; k < 13; k++) write_word(3, 8'(8'h30 + k));
    wait_done(80);
    check("t6_left_in_model", 32'(mq[3].size()), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ts_fifo_bank_arb.md
Name: ts_fifo_bank_arb

Overview:
Single-clock, parametrised N-channel TS input buffer bank. Each channel has a byte-stream FIFO; a packet-granular round-robin arbiter merges the channels into one output stream with ready/valid handshake.
It sits after the per-channel clock-domain crossing and before the QoS scheduler. It replaces fixed 4-instance FIFO wrappers with one block of configurable channel count, depth and packet length. It adds overflow reporting and arbitration.

Parameters:
N_CH, 4, number of input channels (>=2)
DATA_WIDTH, 8, data width per channel
ADDR_WIDTH, 8, per-channel FIFO address bits; DEPTH = 2**ADDR_WIDTH
PKT_LEN, 188, words per packet; must satisfy 2 <= PKT_LEN <= DEPTH
(local) CH_W = max(1, clog2(N_CH)); CNT_W = ADDR_WIDTH+1

Ports:
clk  in  1  single system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
in_data  in  N_CH*DATA_WIDTH  channel i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
in_valid  in  N_CH  per-channel write strobe; no backpressure to sources
out_data  out  DATA_WIDTH  merged stream data
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts word when out_valid && out_ready
out_last  out  1  high with the final (PKT_LEN-th) word of a packet
out_ch  out  CH_W  source channel of current packet
ch_full  out  N_CH  channel FIFO count == DEPTH
ovf  out  N_CH  sticky per-channel overflow flag
ovf_clr  in  N_CH  per-channel clear pulse for ovf

Behaviour:
- Reset (async assert, sync release): all FIFOs empty (pointers and counts 0); state IDLE; out_valid=0, out_last=0, out_ch=0, out_data=0, ch_full=0, ovf=0; round-robin pointer set so channel 0 has first priority.
- Per-channel FIFO: count range 0..DEPTH (CNT_W bits). Pointers wrap modulo DEPTH.
  - Write when in_valid[i] && count<DEPTH.
  - Write when full: the word is dropped, ovf[i] is set, and FIFO contents are unchanged. A read in the same cycle does not rescue the write.
  - Simultaneous write and read on one channel: both occur and count is unchanged.
- ovf[i]: set on a dropped write; cleared by ovf_clr[i]. If a drop and ovf_clr occur in the same cycle, set wins.
- ch_full[i] is registered and reflects count==DEPTH after each edge.
- Eligibility: channel i is eligible when count[i] >= PKT_LEN, evaluated on registered counts.
- FSM states:
  - IDLE: if any channel is eligible, grant the first eligible channel searching from last_grant+1 upward, wrapping modulo N_CH. Latch the grant into out_ch, set last_grant to it, clear the word counter, go to SEND. Otherwise stay in IDLE.
  - SEND: out_valid=1; out_data is the head word of the granted FIFO. On each transfer, pop one word and increment the word counter. out_last=1 when word counter == PKT_LEN-1. A transfer with out_last returns the FSM to IDLE.
- Latency: count reaching PKT_LEN at edge k gives out_valid=1 after edge k+1.
- Back-to-back packets: one IDLE cycle is required between packets (out_valid=0 for exactly 1 cycle).
- Holding rules: while out_valid && !out_ready, out_data, out_last and out_ch are held stable. out_valid never drops mid-packet except on reset.
- Underflow is impossible by construction: a whole packet is present at grant. Writes to the granted channel continue during SEND.
- out_data is 0 when out_valid=0.
- Reset mid-packet: immediate abort; the partial packet and all FIFO contents are discarded.

Test Plan:
(Parameters for all scenarios: N_CH=4, DATA_WIDTH=8, ADDR_WIDTH=4, PKT_LEN=4.)
1. Assert rst mid-run -> out_valid=0, out_last=0, ch_full=0, ovf=0 asynchronously. After release, 3 writes on ch0 -> no out_valid.
2. Write 0x47,0x01,0x02,0x03 on ch2, out_ready=1 -> out_valid one cycle after the 4th write. out_ch=2, data 0x47,0x01,0x02,0x03 in order, out_last only with 0x03, then IDLE.
3. Preload one packet in ch0, ch1 and ch3, out_ready=1 -> packets emitted in order ch0, ch1, ch3, each separated by 1 idle cycle. Refill ch0 during the ch3 packet -> ch0 follows ch3.
4. During a ch1 packet, hold out_ready=0 for 3 cycles at word 2 -> out_data, out_last and out_ch are stable, and no word is lost or duplicated.
5. With out_ready=0, write 17 words 0x00..0x10 to ch1 -> ch_full[1]=1, ovf[1]=1, and 0x10 is dropped. Then pulse ovf_clr[1] -> ovf[1]=0. Pulse ovf_clr[1] in the same cycle as another dropped write -> ovf[1] stays 1.
6. Write and read ch3 simultaneously at count=5 -> count stays 5, and the stream continues without gaps.
